// File: rtl/usb_packet_tx_pkg.sv
// +----------------------------------------------------------------------+
// | usb_packet_tx_pkg : PID codes, CRC16 constants and tx FSM states      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package usb_packet_tx_pkg;

  typedef logic [3:0] pid_t;

  localparam pid_t PID_ACK   = 4'b0010;
  localparam pid_t PID_NAK   = 4'b1010;
  localparam pid_t PID_STALL = 4'b1110;
  localparam pid_t PID_DATA0 = 4'b0011;
  localparam pid_t PID_DATA1 = 4'b1011;

  localparam logic [15:0] CRC16_POLY_REV = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PID    = 3'd1,
    ST_DATA   = 3'd2,
    ST_CRC_LO = 3'd3,
    ST_CRC_HI = 3'd4,
    ST_DONE   = 3'd5
  } tx_state_t;

  function automatic logic [7:0] pid_byte(input pid_t p);
    return {~p, p};
  endfunction

  function automatic logic pid_is_data(input pid_t p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction

  function automatic logic pid_is_handshake(input pid_t p);
    return (p == PID_ACK) || (p == PID_NAK) || (p == PID_STALL);
  endfunction

  function automatic logic pid_supported(input pid_t p);
    return pid_is_data(p) || pid_is_handshake(p);
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_crc16.sv
// +----------------------------------------------------------------------+
// | usb_crc16 : byte-wise USB CRC16 update, LSB first, reflected poly     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module usb_crc16
  import usb_packet_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] w_crc;

  always_comb begin
    w_crc = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (w_crc[0] ^ data[i]) w_crc = (w_crc >> 1) ^ CRC16_POLY_REV;
      else                    w_crc = w_crc >> 1;
    end
  end

  assign crc_out = w_crc;

endmodule

`default_nettype wire

// File: rtl/usb_packet_tx.sv
// +----------------------------------------------------------------------+
// | usb_packet_tx : serialises handshake / data packets (PID, payload,    |
// | CRC16) to the SIE. Option macro USB_TX_TOGGLE_EN: DATA0/1 toggling.   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module usb_packet_tx
  import usb_packet_tx_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  pid_t       cmd_pid,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  input  logic       data_empty,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err_underrun
`ifdef USB_TX_TOGGLE_EN
  ,
  input  logic       ack_rcvd,
  input  logic       setup_rcvd,
  output logic       toggle
`endif
);

  localparam int                 c_cnt_w   = $clog2(MAX_PAYLOAD + 1);
  localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_PAYLOAD);

  tx_state_t          r_state, w_state;
  logic [7:0]         r_tx_data, w_tx_data;
  logic               r_tx_valid, w_tx_valid;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_err, w_err;
  logic [15:0]        r_crc, w_crc, w_crc_upd;
  logic [c_cnt_w-1:0] r_count, w_count, w_count_inc;
  logic               r_is_data, w_is_data;
  logic               r_empty, w_empty;
  logic               r_last, w_last;
  logic               w_fetch_slot, w_fetch, w_finish;
  pid_t               w_pid_sel;

  usb_crc16 u_crc16 (
    .crc_in  (r_crc),
    .data    (data_in),
    .crc_out (w_crc_upd)
  );

`ifdef USB_TX_TOGGLE_EN
  logic r_toggle;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_toggle <= 1'b0;
    else if (setup_rcvd) r_toggle <= 1'b1;
    else if (ack_rcvd)   r_toggle <= ~r_toggle;
  end

  assign toggle    = r_toggle;
  assign w_pid_sel = pid_is_data(cmd_pid) ? (r_toggle ? PID_DATA1 : PID_DATA0) : cmd_pid;
`else
  assign w_pid_sel = cmd_pid;
`endif

  assign w_count_inc = r_count + c_cnt_w'(1);
  // A payload byte is pulled when the SIE takes the PID of a non-empty data
  // packet or a payload byte that was not the last one.
  assign w_fetch_slot = ((r_state == ST_PID) && r_is_data && !r_empty) ||
                        ((r_state == ST_DATA) && !r_last);
  assign data_ready   = w_fetch_slot && tx_ready && data_valid;
  assign cmd_ready    = (r_state == ST_IDLE);

  always_comb begin
    w_state    = r_state;
    w_tx_data  = r_tx_data;
    w_tx_valid = r_tx_valid;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_crc      = r_crc;
    w_count    = r_count;
    w_is_data  = r_is_data;
    w_empty    = r_empty;
    w_last     = r_last;
    w_fetch    = 1'b0;
    w_finish   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (pid_supported(cmd_pid)) begin
            w_state    = ST_PID;
            w_tx_data  = pid_byte(w_pid_sel);
            w_tx_valid = 1'b1;
            w_busy     = 1'b1;
            w_is_data  = pid_is_data(cmd_pid);
            w_empty    = data_empty;
            w_crc      = CRC16_INIT;
            w_count    = '0;
            w_last     = 1'b0;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      ST_PID: begin
        if (tx_ready) begin
          if (!r_is_data) begin
            w_finish = 1'b1;
          end else if (r_empty) begin
            w_state   = ST_CRC_LO;
            w_tx_data = ~r_crc[7:0];
          end else begin
            w_fetch = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tx_ready) begin
          if (r_last) begin
            w_state   = ST_CRC_LO;
            w_tx_data = ~r_crc[7:0];
          end else begin
            w_fetch = 1'b1;
          end
        end
      end
      ST_CRC_LO: begin
        if (tx_ready) begin
          w_state   = ST_CRC_HI;
          w_tx_data = ~r_crc[15:8];
        end
      end
      ST_CRC_HI: begin
        if (tx_ready) w_finish = 1'b1;
      end
      ST_DONE: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    if (w_fetch) begin
      if (data_valid) begin
        w_state   = ST_DATA;
        w_tx_data = data_in;
        w_crc     = w_crc_upd;
        w_count   = w_count_inc;
        w_last    = data_last || (w_count_inc == c_max_cnt);
      end else begin
        // Dropping tx_valid mid-packet makes the SIE emit EOP; host sees bad CRC.
        w_state    = ST_IDLE;
        w_tx_valid = 1'b0;
        w_busy     = 1'b0;
        w_err      = 1'b1;
        w_crc      = CRC16_INIT;
        w_count    = '0;
      end
    end

    if (w_finish) begin
      w_state    = ST_DONE;
      w_tx_valid = 1'b0;
      w_busy     = 1'b0;
      w_done     = 1'b1;
      w_crc      = CRC16_INIT;
      w_count    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_crc      <= CRC16_INIT;
      r_count    <= '0;
      r_is_data  <= 1'b0;
      r_empty    <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_tx_data  <= w_tx_data;
      r_tx_valid <= w_tx_valid;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
      r_crc      <= w_crc;
      r_count    <= w_count;
      r_is_data  <= w_is_data;
      r_empty    <= w_empty;
      r_last     <= w_last;
    end
  end

  assign tx_data      = r_tx_data;
  assign tx_valid     = r_tx_valid;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err_underrun = r_err;

endmodule

`default_nettype wire

// File: tb/tb_usb_packet_tx.sv
// +----------------------------------------------------------------------+
// | tb_usb_packet_tx : scoreboard bench for usb_packet_tx                 |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_usb_packet_tx;
  import usb_packet_tx_pkg::*;

  // MAX_PAYLOAD=9 lets the truncation case reuse the "123456789" CRC vector.
  localparam int MAXP = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  pid_t       cmd_pid = PID_ACK;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_last = 1'b0;
  logic       data_empty = 1'b0;
  logic       tx_ready = 1'b0;
  logic       cmd_ready, data_ready, tx_valid, busy, done, err_underrun;
  logic [7:0] tx_data;
`ifdef USB_TX_TOGGLE_EN
  logic       ack_rcvd = 1'b0;
  logic       setup_rcvd = 1'b0;
  logic       toggle;
  logic       model_toggle = 1'b0;
`endif

  int         n_checks = 0;
  int         n_fail = 0;
  int         n_done = 0;
  int         n_err = 0;
  int         n_dready = 0;
  int         ready_div = 1;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] src[$];
  logic       src_last = 1'b0;
  logic       took = 1'b0;

  usb_packet_tx #(.MAX_PAYLOAD(MAXP)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_pid      (cmd_pid),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_last    (data_last),
    .data_ready   (data_ready),
    .data_empty   (data_empty),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .done         (done),
    .err_underrun (err_underrun)
`ifdef USB_TX_TOGGLE_EN
    ,
    .ack_rcvd     (ack_rcvd),
    .setup_rcvd   (setup_rcvd),
    .toggle       (toggle)
`endif
  );

  always #21 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Payload source and SIE tx_ready pacing.
  initial forever begin
    @(negedge clk);
    took = data_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (took && src.size() > 0) src.delete(0);
    tx_ready   = (ready_div <= 1) || (cyc % ready_div == 0);
    data_valid = (src.size() > 0);
    data_in    = (src.size() > 0) ? src[0] : 8'h00;
    data_last  = src_last && (src.size() == 1);
  end

  // Monitor: every byte the SIE takes is compared with the scoreboard head.
  initial forever begin
    logic [7:0] exp;
    @(negedge clk);
    if (done)         n_done++;
    if (err_underrun) n_err++;
    if (data_ready)   n_dready++;
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got %0h, expected no byte", tx_data);
      end else begin
        exp = exp_q.pop_front();
        check("tx_byte", 32'(tx_data), 32'(exp));
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no end of test, expected finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] data_pid(input pid_t p);
`ifdef USB_TX_TOGGLE_EN
    return pid_is_data(p) ? (model_toggle ? 8'h4B : 8'hC3) : 8'h00;
`else
    return (p == PID_DATA1) ? 8'h4B : 8'hC3;
`endif
  endfunction

  task automatic load_src(input int n, input logic last);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(8'h31 + 8'(i));
    src_last = last;
  endtask

  task automatic push_digits_packet(input pid_t p);
    exp_q.push_back(data_pid(p));
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
    exp_q.push_back(8'hC8);
    exp_q.push_back(8'hB4);
  endtask

  task automatic send_cmd(input pid_t p, input logic empty);
    @(negedge clk);
    #2;
    check("cmd_ready_before_cmd", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b1;
    cmd_pid    = p;
    data_empty = empty;
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
  endtask

  task automatic finish_case(input string name, input int d0, input int e0,
                             input int exp_done, input int exp_err);
    int k = 0;
    while (n_done == d0 && n_err == e0 && k < 400) begin
      @(negedge clk);
      #2;
      k++;
    end
    check({name, "_timeout"}, 32'(k < 400), 1);
    check({name, "_tx_valid_at_end"}, 32'(tx_valid), 0);
    check({name, "_busy_at_end"}, 32'(busy), 0);
    if (exp_err != 0) check({name, "_cmd_ready_after_err"}, 32'(cmd_ready), 1);
    repeat (3) begin
      @(negedge clk);
      #2;
    end
    check({name, "_done_count"}, n_done - d0, exp_done);
    check({name, "_err_count"}, n_err - e0, exp_err);
    check({name, "_bytes_left"}, exp_q.size(), 0);
  endtask

`ifdef USB_TX_TOGGLE_EN
  task automatic pulse_ctl(input logic is_setup);
    @(posedge clk);
    #1;
    if (is_setup) setup_rcvd = 1'b1;
    else          ack_rcvd   = 1'b1;
    @(posedge clk);
    #1;
    setup_rcvd   = 1'b0;
    ack_rcvd     = 1'b0;
    model_toggle = is_setup ? 1'b1 : ~model_toggle;
  endtask
`endif

  initial begin
    int d0, e0, dr0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err_underrun), 0);
    check("rst_data_ready", 32'(data_ready), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Handshake with a slow SIE.
    ready_div = 4;
    d0 = n_done; e0 = n_err; dr0 = n_dready;
    exp_q.push_back(8'hD2);
    send_cmd(PID_ACK, 1'b0);
    finish_case("ack", d0, e0, 1, 0);
    check("ack_no_data_ready", n_dready - dr0, 0);

    ready_div = 1;
    d0 = n_done; e0 = n_err;
    exp_q.push_back(8'h1E);
    send_cmd(PID_STALL, 1'b0);
    finish_case("stall", d0, e0, 1, 0);

    // Zero-length data packet: CRC of nothing is ~FFFF = 0000.
    d0 = n_done; e0 = n_err;
    exp_q.push_back(data_pid(PID_DATA1));
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    send_cmd(PID_DATA1, 1'b1);
    finish_case("zlp", d0, e0, 1, 0);

    // "123456789": USB CRC16 = B4C8, sent low byte first.
    for (int r = 0; r < 2; r++) begin
      ready_div = (r == 0) ? 1 : 3;
      d0 = n_done; e0 = n_err;
      load_src(9, 1'b1);
      push_digits_packet(PID_DATA0);
      send_cmd(PID_DATA0, 1'b0);
      finish_case("crc", d0, e0, 1, 0);
      check("crc_src_drained", src.size(), 0);
    end

    // Underrun: source runs dry on the third payload request.
    ready_div = 1;
    d0 = n_done; e0 = n_err;
    load_src(2, 1'b0);
    exp_q.push_back(data_pid(PID_DATA0));
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h32);
    send_cmd(PID_DATA0, 1'b0);
    finish_case("underrun", d0, e0, 0, 1);

    // Truncation at MAX_PAYLOAD without data_last.
    d0 = n_done; e0 = n_err;
    load_src(11, 1'b0);
    push_digits_packet(PID_DATA0);
    send_cmd(PID_DATA0, 1'b0);
    finish_case("trunc", d0, e0, 1, 0);
    check("trunc_left_in_source", src.size(), 2);
    src.delete();

    // Unsupported PID: accepted and dropped, done only.
    d0 = n_done; e0 = n_err;
    send_cmd(4'b0000, 1'b0);
    finish_case("bad_pid", d0, e0, 1, 0);

    // Asynchronous reset in the middle of the payload.
    ready_div = 4;
    load_src(9, 1'b1);
    push_digits_packet(PID_DATA0);
    send_cmd(PID_DATA0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2;
    check("busy_mid_packet", 32'(busy), 1);
    d0 = n_done;
    #5;
    reset = 1'b0;
    #1;
    check("rst_mid_tx_valid", 32'(tx_valid), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 1);
    exp_q.delete();
    src.delete();
`ifdef USB_TX_TOGGLE_EN
    model_toggle = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("rst_mid_no_done", n_done - d0, 0);

    ready_div = 2;
    d0 = n_done; e0 = n_err;
    exp_q.push_back(8'h5A);
    send_cmd(PID_NAK, 1'b0);
    finish_case("nak_after_reset", d0, e0, 1, 0);

`ifdef USB_TX_TOGGLE_EN
    ready_div = 1;
    pulse_ctl(1'b0);
    pulse_ctl(1'b0);
    check("toggle_after_two_acks", 32'(toggle), 0);
    d0 = n_done; e0 = n_err;
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    send_cmd(PID_DATA1, 1'b1);
    finish_case("tog_ack", d0, e0, 1, 0);
    pulse_ctl(1'b1);
    check("toggle_after_setup", 32'(toggle), 1);
    d0 = n_done; e0 = n_err;
    exp_q.push_back(8'h4B);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    send_cmd(PID_DATA0, 1'b1);
    finish_case("tog_setup", d0, e0, 1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
